// File: rtl/angle_reducer_pkg.sv
// Shared cosine package: angle constants derived from the fractional width
// and the reducer state encoding, reused by the cosine controller/datapath.
package angle_reducer_pkg;

   // pi scaled by 2^30, rounded; narrower formats are derived from it
   localparam longint PI_Q30 = 64'sd3373259426;

   // Default fixed-point format of the cosine pipeline
   localparam int COS_W    = 16;
   localparam int COS_FRAC = 12;

   // Round-to-nearest pi in Q.frac (valid for frac <= 29)
   function automatic longint pi_fixed(input int frac);
      longint half_lsb;
      half_lsb = 64'sd1 <<< (29 - frac);
      return (PI_Q30 + half_lsb) >>> (30 - frac);
   endfunction

   // pi/2 and 2*pi are taken from the rounded pi so they stay exactly consistent
   function automatic longint half_pi_fixed(input int frac);
      return pi_fixed(frac) >>> 1;
   endfunction

   function automatic longint two_pi_fixed(input int frac);
      return pi_fixed(frac) <<< 1;
   endfunction

   // Constants at the default format: 12868, 6434, 25736
   localparam longint PI      = pi_fixed(COS_FRAC);
   localparam longint HALF_PI = half_pi_fixed(COS_FRAC);
   localparam longint TWO_PI  = two_pi_fixed(COS_FRAC);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REDUCE = 2'd1,
      ST_FOLD   = 2'd2,
      ST_HOLD   = 2'd3
   } red_state_t;

endpackage

// File: rtl/angle_reducer.sv
// Angle range reducer: maps a signed angle to x in [0, pi/2] plus a sign flag
// such that cos(angle) = neg ? -cos(x) : cos(x).
module angle_reducer
   import angle_reducer_pkg::*;
#(
   parameter int W    = 16,
   parameter int FRAC = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] angle,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] x_out,
   output logic         neg
);

   localparam longint PI_L      = pi_fixed(FRAC);
   localparam longint HALF_PI_L = half_pi_fixed(FRAC);
   localparam longint TWO_PI_L  = two_pi_fixed(FRAC);

   // One guard bit above W keeps every correction and |a| free of overflow
   localparam logic signed [W:0] PI_S      = PI_L[W:0];
   localparam logic signed [W:0] NEG_PI_S  = -PI_S;
   localparam logic signed [W:0] HALF_PI_S = HALF_PI_L[W:0];
   localparam logic signed [W:0] TWO_PI_S  = TWO_PI_L[W:0];

   red_state_t         state_q, state_d;
   logic signed [W:0]  a_q, a_d;
   logic [W-1:0]       x_out_q, x_out_d;
   logic               neg_q, neg_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic signed [W:0]  m_s;

   // Magnitude of the reduced angle; a lies in [-pi, pi) when it is used
   always_comb begin
      if (a_q[W]) begin
         m_s = -a_q;
      end else begin
         m_s = a_q;
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      x_out_d = x_out_q;
      neg_d   = neg_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = {angle[W-1], angle};
               state_d = ST_REDUCE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REDUCE: begin
            // A single 2*pi correction per cycle
            if (a_q >= PI_S) begin
               a_d = a_q - TWO_PI_S;
            end else if (a_q < NEG_PI_S) begin
               a_d = a_q + TWO_PI_S;
            end else begin
               state_d = ST_FOLD;
            end
         end
         ST_FOLD: begin
            // Beyond pi/2 use cos(m) = -cos(pi - m)
            if (m_s > HALF_PI_S) begin
               x_out_d = W'(PI_S - m_s);
               neg_d   = 1'b1;
            end else begin
               x_out_d = W'(m_s);
               neg_d   = 1'b0;
            end
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_HOLD);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         a_q         <= {(W+1){1'b0}};
         x_out_q     <= {W{1'b0}};
         neg_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         x_out_q     <= x_out_d;
         neg_q       <= neg_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign x_out     = x_out_q;
   assign neg       = neg_q;

endmodule

// File: tb/tb_angle_reducer.sv
// Scoreboard bench for angle_reducer: the driver pushes hand-computed results,
// an independent monitor pops and compares on each output handshake.
module tb_angle_reducer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] angle;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] x_out;
   logic        neg;

   typedef struct {
      logic [15:0] x;
      logic        ng;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   angle_reducer #(.W(16), .FRAC(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .angle     (angle),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .neg       (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter: number of rising edges seen so far
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: compare every handshake against the scoreboard head
   initial begin
      logic prev_valid;
      int   first_cyc;
      exp_t e;
      prev_valid = 1'b0;
      first_cyc  = 0;
      forever begin
         @(negedge clk);
         if (out_valid && !prev_valid) first_cyc = cyc;
         prev_valid = out_valid;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("x_out", {16'd0, x_out}, {16'd0, e.x});
               chk("neg", {31'd0, neg}, {31'd0, e.ng});
               chk("latency", first_cyc - e.acc, e.lat);
            end
         end
      end
   end

   // Present one angle; inputs change 2 time units after a rising edge
   task automatic send(input logic [15:0] a, input logic [15:0] x, input logic ng, input int lat);
      int t;
      exp_t e;
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 32'd0, 32'd1);
      end else begin
         in_valid = 1'b1;
         angle    = a;
         e.x = x; e.ng = ng; e.lat = lat; e.acc = cyc + 1;
         sb.push_back(e);
         @(posedge clk); #2;
         in_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b0; in_valid = 1'b0; angle = 16'd0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_x_out", {16'd0, x_out}, 32'd0);
      chk("rst_neg", {31'd0, neg}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #2;

      // Directed vectors: angle, x_out, neg, latency
      send(16'd0,     16'd0,    1'b0, 2);
      send(16'd10240, 16'd2628, 1'b1, 2);
      send(16'd28672, 16'd2936, 1'b0, 3);
      send(16'h8000,  16'd5836, 1'b1, 3);   // -32768
      send(16'd12868, 16'd0,    1'b1, 3);   // exactly pi
      send(16'd6434,  16'd6434, 1'b0, 2);   // exactly pi/2
      send(16'd6435,  16'd6433, 1'b1, 2);
      send(16'd3000,  16'd3000, 1'b0, 2);
      send(-16'sd10240, 16'd2628, 1'b1, 2);
      send(-16'sd12868, 16'd0,    1'b1, 2); // -pi needs no correction
      send(-16'sd12869, 16'd1,    1'b1, 3);
      send(16'd32767, 16'd5837, 1'b1, 3);
      send(16'd12867, 16'd1,    1'b1, 2);

      // Back-pressure: hold the result while in_valid toggles
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #2; t++; end
      out_ready = 1'b0;
      send(16'd10240, 16'd2628, 1'b1, 2);
      t = 0;
      while (!out_valid && t < 20) begin @(posedge clk); #2; t++; end
      chk("stall_reached_hold", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         angle    = 16'd3000;
         chk("stall_x_out", {16'd0, x_out}, 32'd2628);
         chk("stall_neg", {31'd0, neg}, 32'd1);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         @(posedge clk); #2;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (6) @(posedge clk);
      #2;

      // Reset in the middle of a reduction discards the transaction
      in_valid = 1'b1;
      angle    = 16'd28672;
      @(posedge clk); #2;
      in_valid = 1'b0;
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #2;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_x_out", {16'd0, x_out}, 32'd0);
      chk("midrst_neg", {31'd0, neg}, 32'd0);
      rst = 1'b1;
      repeat (8) @(posedge clk);
      #2;

      // One more vector after the reset to confirm normal operation resumes
      send(16'd28672, 16'd2936, 1'b0, 3);
      repeat (8) @(posedge clk);
      #2;
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/angle_reducer.md
ANGLE_REDUCER -- requirements
Module: angle_reducer

Interface
REQ-001 SHALL have parameter W, default 16, total width of signed fixed-point angle words.
REQ-002 SHALL have parameter FRAC, default 12, number of fractional bits; PI=12868, HALF_PI=6434, TWO_PI=25736 at defaults.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 in_valid  input  1  upstream presents angle.
REQ-006 angle  input  W  signed two's-complement radians, Q(W-FRAC-1).FRAC.
REQ-007 in_ready  output  1  block can accept angle.
REQ-008 out_valid  output  1  x_out/neg are valid for the downstream cosine engine.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 x_out  output  W  reduced angle, unsigned value in [0, HALF_PI], MSB always 0.
REQ-011 neg  output  1  downstream SHALL negate cos(x_out) to obtain cos(angle).

Function
REQ-012 SHALL implement FSM states IDLE, REDUCE, FOLD, HOLD.
REQ-013 IDLE: in_ready=1; on in_valid=1, capture angle into W+1-bit signed register a, go REDUCE.
REQ-014 REDUCE: if a >= PI, a <= a - TWO_PI, stay; else if a < -PI, a <= a + TWO_PI, stay; else go FOLD; one correction per cycle.
REQ-015 REDUCE SHALL take k+1 cycles where k (0..2) is the number of corrections; exit interval is [-PI, PI).
REQ-016 FOLD: m = |a|; if m > HALF_PI then x_out <= PI - m, neg <= 1, else x_out <= m, neg <= 0; go HOLD.
REQ-017 HOLD: out_valid=1; x_out/neg held stable while out_ready=0; on out_ready=1 go IDLE next cycle.
REQ-018 Latency from accepting edge to first out_valid cycle SHALL be k+2 cycles; throughput one angle per k+4 cycles minimum.
REQ-019 in_ready SHALL be 0 in REDUCE, FOLD, HOLD; in_valid then ignored, no capture.
REQ-020 out_valid SHALL be 0 outside HOLD; out_ready outside HOLD ignored.
REQ-021 Internal arithmetic SHALL be W+1 bits signed; no overflow for any W-bit input.
REQ-022 Boundary: m == HALF_PI -> x_out=HALF_PI, neg=0; a == PI on entry -> corrected to -PI, result x_out=0, neg=1.

Reset
REQ-023 rst=0 at a clk edge SHALL force IDLE, a=0, x_out=0, neg=0, out_valid=0, in_ready=1 after the edge, from any state including mid-REDUCE or HOLD.
REQ-024 A transaction interrupted by reset SHALL be discarded; no out_valid produced for it.

Structure
REQ-025 Constants PI, HALF_PI, TWO_PI (derived from FRAC) and state encoding SHALL reside in the shared cosine package, reused by the cosine controller/datapath.
REQ-026 Block SHALL be a single module; no sub-module is natural.
REQ-027 Next-state and output decode SHALL be combinational blocks separate from the state register, registered outputs x_out/neg.

Verification
REQ-028 angle=0 -> after 2 cycles out_valid=1, x_out=0, neg=0.
REQ-029 angle=10240 (2.5 rad) -> x_out=2628, neg=1, latency 2.
REQ-030 angle=28672 (7.0 rad) -> one correction, x_out=2936, neg=0, latency 3; angle=-32768 -> x_out=5836, neg=1, latency 3.
REQ-031 angle=12868 (PI) -> x_out=0, neg=1; angle=6434 -> x_out=6434, neg=0.
REQ-032 out_ready held 0 for 5 cycles in HOLD with in_valid=1 toggling -> outputs stable, in_ready=0, no new capture; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-033 rst=0 asserted during REDUCE of angle=28672 -> next cycle IDLE, all outputs at reset values, no out_valid for that angle.
